// File: rtl/spi_link_arbiter.sv
`default_nettype none
// ==========================================================================
// spi_link_arbiter - round-robin scheduler sharing one SPI byte link (rev 1.0)
// ==========================================================================
module spi_link_arbiter #(
  parameter int N_REQ = 4,
  parameter int BITS  = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] tx_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         rx_data,
  output logic               busy,
  output logic               err,
  output logic [7:0]         s_data,
  output logic               s_write,
  output logic               s_te,
  input  logic               s_empty,
  output logic               r_read,
  output logic               r_re,
  input  logic               r_full,
  input  logic [7:0]         r_data
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(BITS) + 1;
  localparam logic [CW-1:0] BCNT_LAST = CW'(BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [GW-1:0]    g, ptr, pick, idx;
  logic             pick_valid;
  logic [CW-1:0]    bcnt;
  logic [N_REQ-1:0] g_onehot;
  logic [7:0]       tx_byte [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_tx_bytes
    assign tx_byte[i] = tx_data[8*i +: 8];
  end

  assign g_onehot = N_REQ'(1) << g;

  // Search starts one past the last served requester so it has lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick       = ptr;
    idx        = ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = GW'((int'(ptr) + k) % N_REQ);
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = '0;
    busy      = 1'b1;
    s_write   = 1'b0;
    s_te      = 1'b0;
    r_read    = 1'b0;
    r_re      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pick_valid) state_nxt = LOAD;
      end
      LOAD: begin
        gnt       = g_onehot;
        s_write   = 1'b1;
        r_read    = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        gnt  = g_onehot;
        s_te = 1'b1;
        r_re = 1'b1;
        if (bcnt == BCNT_LAST) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        gnt       = g_onehot;
        r_read    = 1'b1;
        state_nxt = FIN;
      end
      FIN: begin
        gnt       = g_onehot;
        done      = g_onehot;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      bcnt    <= '0;
      g       <= '0;
      ptr     <= GW'(N_REQ - 1);
      s_data  <= '0;
      rx_data <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      bcnt  <= (state == SHIFT && bcnt != BCNT_LAST) ? bcnt + 1'b1 : '0;
      if (state == IDLE && pick_valid) begin
        g      <= pick;
        s_data <= tx_byte[pick];
      end
      // Both sides must report a complete byte at capture time.
      if (state == CAPTURE) begin
        rx_data <= r_data;
        if (!s_empty || !r_full) err <= 1'b1;
      end
      if (state == FIN) ptr <= g;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_spi_link_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_spi_link_arbiter - table, hand-written and randomized checks with a loopback link model.
module tb_spi_link_arbiter;
  localparam int N    = 4;
  localparam int BITS = 8;

  logic           clk = 1'b0;
  logic           clr = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] tx_data = '0;
  logic [N-1:0]   gnt, done;
  logic [7:0]     rx_data, s_data, r_data;
  logic           busy, err, s_write, s_te, s_empty, r_read, r_re, r_full;

  int n_pass  = 0;
  int n_total = 0;
  int model_ptr = N - 1;

  spi_link_arbiter #(.N_REQ(N), .BITS(BITS)) dut (
    .clk(clk), .clr(clr), .req(req), .tx_data(tx_data),
    .gnt(gnt), .done(done), .rx_data(rx_data), .busy(busy), .err(err),
    .s_data(s_data), .s_write(s_write), .s_te(s_te), .s_empty(s_empty),
    .r_read(r_read), .r_re(r_re), .r_full(r_full), .r_data(r_data)
  );

  always #5 clk = ~clk;

  // Sender/receiver pair wired in loopback: sender MSB feeds receiver LSB.
  logic [7:0] snd_sr = '0;
  logic [7:0] rcv_sr = '0;
  int  snd_cnt = 0;
  int  rcv_cnt = 0;
  bit  kill_full = 1'b0;

  always @(posedge clk) begin
    if (s_write) begin
      snd_sr  <= s_data;
      snd_cnt <= 0;
    end else if (s_te) begin
      snd_sr  <= {snd_sr[6:0], 1'b0};
      snd_cnt <= snd_cnt + 1;
    end
    if (r_re) begin
      rcv_sr  <= {rcv_sr[6:0], snd_sr[7]};
      rcv_cnt <= rcv_cnt + 1;
    end else if (r_read) begin
      rcv_cnt <= 0;
    end
  end

  assign s_empty = (snd_cnt == BITS);
  assign r_full  = (rcv_cnt == BITS) && !kill_full;
  assign r_data  = rcv_sr;

  typedef struct {
    logic [N-1:0]   r;
    logic [8*N-1:0] tx;
    logic [N-1:0]   g;
    logic [7:0]     rx;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h, expected %0h", tag, name, act, exp);
  endtask

  // Reference arbitration: first set request strictly after the last winner, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    req = '0;
    kill_full = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    model_ptr = N - 1;
  endtask

  task automatic run_xfer(input string tag, input logic [N-1:0] r, input logic [8*N-1:0] tx,
                          input logic [N-1:0] exp_g, input logic [7:0] exp_rx,
                          input logic [N-1:0] mid_req, input bit use_mid,
                          input bit kill, input bit exp_err);
    int lat = -1;
    int n_wr = 0;
    int n_te = 0;
    int bad_gnt = 0;
    int bad_busy = 0;
    req = r;
    tx_data = tx;
    @(posedge clk); #1;
    for (int i = 0; i < 30 && lat < 0; i++) begin
      if (s_write) n_wr++;
      if (s_te) n_te++;
      if (gnt !== exp_g) bad_gnt++;
      if (busy !== 1'b1) bad_busy++;
      if (done !== '0) begin
        lat = i;
        check(tag, "done", done, exp_g);
        check(tag, "rx_data", rx_data, exp_rx);
        check(tag, "err", err, exp_err);
      end
      if (use_mid && i == 4) req = mid_req;
      if (kill && i == 9) kill_full = 1'b1;
      if (lat < 0) begin
        @(posedge clk); #1;
        kill_full = 1'b0;
      end
    end
    check(tag, "latency", lat, BITS + 2);
    check(tag, "write_cycles", n_wr, 1);
    check(tag, "te_cycles", n_te, BITS);
    check(tag, "gnt_mismatch_cycles", bad_gnt, 0);
    check(tag, "busy_low_cycles", bad_busy, 0);
    req = '0;
    @(posedge clk); #1;
    check(tag, "idle_after", {busy, gnt, done}, 0);
    @(negedge clk);
  endtask

  int             bad, w, rr_n;
  int             rr_t [5];
  logic [N-1:0]   rr_g [5];
  logic [7:0]     rr_rx [5];
  logic [N-1:0]   rv, eg, mid;
  logic [8*N-1:0] txv, sh;

  initial begin
    tbl[0] = '{4'b0010, 32'h0000A500, 4'b0010, 8'hA5};
    tbl[1] = '{4'b1111, 32'h44332211, 4'b0100, 8'h33};
    tbl[2] = '{4'b0011, 32'h00005A3C, 4'b0001, 8'h3C};
    tbl[3] = '{4'b0001, 32'h000000FF, 4'b0001, 8'hFF};
    tbl[4] = '{4'b1001, 32'h81000000, 4'b1000, 8'h81};
    tbl[5] = '{4'b0110, 32'h00C37E00, 4'b0010, 8'h7E};

    // Reset values
    #2 clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", "outputs_in_reset",
          {gnt, done, busy, err, rx_data, s_data, s_write, s_te, r_read, r_re}, 0);
    clr = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if ({gnt, done, busy, err, s_write, s_te, r_read, r_re} !== '0) bad++;
    end
    check("reset", "active_cycles_idle", bad, 0);
    check("reset", "rx_data", rx_data, 0);

    // Table-driven transfers from the reset pointer
    for (int t = 0; t < 6; t++)
      run_xfer($sformatf("tbl%0d", t), tbl[t].r, tbl[t].tx, tbl[t].g, tbl[t].rx, '0, 1'b0, 1'b0, 1'b0);

    // Request drop mid-shift and late request from another requester
    do_reset();
    run_xfer("drop", 4'b0100, 32'h00960000, 4'b0100, 8'h96, 4'b0001, 1'b1, 1'b0, 1'b0);
    run_xfer("late", 4'b0001, 32'h00000069, 4'b0001, 8'h69, '0, 1'b0, 1'b0, 1'b0);

    // Reset during the 4th shift cycle
    do_reset();
    req = 4'b1000;
    tx_data = 32'hE7000000;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    check("midrst", "shifting", s_te, 1);
    clr = 1'b0;
    #1;
    check("midrst", "outputs_now", {gnt, done, busy, s_write, s_te, r_read, r_re, rx_data}, 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if ({done, busy, gnt} !== '0) bad++;
    end
    check("midrst", "held_cycles_active", bad, 0);
    clr = 1'b1;
    model_ptr = N - 1;
    run_xfer("after_rst", 4'b1000, 32'hE7000000, 4'b1000, 8'hE7, '0, 1'b0, 1'b0, 1'b0);

    // Sticky error
    do_reset();
    run_xfer("err", 4'b0001, 32'h000000C5, 4'b0001, 8'hC5, '0, 1'b0, 1'b1, 1'b1);
    run_xfer("err_sticky", 4'b0010, 32'h00005B00, 4'b0010, 8'h5B, '0, 1'b0, 1'b0, 1'b1);
    do_reset();
    check("err", "cleared_by_reset", err, 0);

    // Continuous requests: rotation order and spacing
    do_reset();
    for (int j = 0; j < 5; j++) begin
      rr_t[j] = 0; rr_g[j] = '0; rr_rx[j] = '0;
    end
    rr_n = 0;
    req = 4'b1111;
    tx_data = 32'h4D3C2B1A;
    for (int c = 0; c < 100 && rr_n < 5; c++) begin
      @(posedge clk); #1;
      if (done !== '0) begin
        rr_g[rr_n] = done;
        rr_rx[rr_n] = rx_data;
        rr_t[rr_n] = c;
        rr_n++;
        if (rr_n == 5) req = '0;
      end
    end
    check("rr", "done_count", rr_n, 5);
    for (int j = 0; j < 5; j++) begin
      check("rr", $sformatf("grant%0d", j), rr_g[j], 4'(1) << (j % 4));
      txv = tx_data >> (8 * (j % 4));
      check("rr", $sformatf("rx%0d", j), rr_rx[j], txv[7:0]);
    end
    for (int j = 1; j < 5; j++)
      check("rr", $sformatf("spacing%0d", j), rr_t[j] - rr_t[j-1], BITS + 4);
    repeat (2) @(posedge clk);
    #1;
    check("rr", "idle_after", busy, 0);

    // Randomized traffic against the reference arbiter
    do_reset();
    for (int n = 0; n < 30; n++) begin
      rv  = 4'($urandom_range(1, 15));
      txv = $urandom;
      mid = 4'($urandom);
      w   = rr_pick(rv, model_ptr);
      eg  = 4'(1) << w;
      sh  = txv >> (8 * w);
      run_xfer($sformatf("rand%0d", n), rv, txv, eg, sh[7:0], mid, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      model_ptr = w;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/spi_link_arbiter.md
# spi_link_arbiter

Round-robin scheduler that shares one SENDER/RECEIVER SPI byte link between N_REQ requesters. For each granted requester it runs a full-duplex 8-bit transfer: load and flush, gated shift, capture. It then returns the received byte with a one-cycle DONE pulse. The block sits between the client logic and the SENDER/RECEIVER pair, and it owns every strobe (WRITE, TE, RE, READ) on that pair.

## Interface
- N_REQ, 4, number of requesters (2..8)
- BITS, 8, shift cycles per transfer; must equal the shift-register width
- CLK  in  1  system clock; all state updates on rising edge
- CLR  in  1  asynchronous, active-low reset
- REQ  in  N_REQ  per-requester transfer request; level, held until DONE
- TX_DATA  in  8*N_REQ  byte to send; requester i uses bits [8i+7:8i]
- GNT  out  N_REQ  one-hot grant; high from LOAD through DONE
- DONE  out  N_REQ  one-cycle pulse to the granted requester on completion
- RX_DATA  out  8  captured receive byte; valid while DONE is high, held afterwards
- BUSY  out  1  high in every state except IDLE
- ERR  out  1  sticky link-consistency error; cleared only by reset
- S_DATA  out  8  parallel byte to SENDER DATA
- S_WRITE  out  1  SENDER WRITE (parallel load)
- S_TE  out  1  SENDER TE
- S_EMPTY  in  1  SENDER EMPTY_STATE
- R_READ  out  1  RECEIVER READ (count clear / data enable)
- R_RE  out  1  RECEIVER RE
- R_FULL  in  1  RECEIVER FULL_STATE
- R_DATA  in  8  RECEIVER DATA

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE, FIN.
- All outputs are registered or decoded from registered state. No combinational path from REQ to GNT.
- **IDLE**
  - If any REQ bit is set, pick the winner by round-robin, searching upward from PTR+1 modulo N_REQ.
  - Latch the winner index G and TX_DATA[G] into S_DATA. Go to LOAD.
  - If no REQ bit is set, stay in IDLE.
- **LOAD** (1 cycle)
  - S_WRITE=1 and R_READ=1. This loads the sender and clears the receiver count.
  - GNT[G]=1. Go to SHIFT.
- **SHIFT** (BITS cycles)
  - S_TE=1 and R_RE=1.
  - A bit counter BCNT (width clog2(BITS)+1) starts at 0 and increments each cycle.
  - When BCNT==BITS-1, go to CAPTURE.
- **CAPTURE** (1 cycle)
  - R_READ=1. Register R_DATA into RX_DATA at the end of the cycle.
  - If S_EMPTY==0 or R_FULL==0 in this cycle, set ERR.
  - Go to FIN.
- **FIN** (1 cycle)
  - DONE[G]=1 and GNT[G]=1. Set PTR=G. Go to IDLE.
- Strobes not named for a state are 0 in that state. S_TE and R_RE are never high outside SHIFT.
- If REQ[G] drops after the grant, the transfer still completes and DONE still pulses.
- A new REQ from a requester that is not granted is only considered in the next IDLE.
- The same requester may win again only if no other REQ bit is set, because PTR has moved past it.
- BCNT wraps only through the state change and never exceeds BITS-1. TX_DATA is sampled only in IDLE.
- **Reset** (CLR low, at any time, including mid-SHIFT)
  - Asynchronous return to IDLE.
  - GNT, DONE, and all strobes go to 0. BUSY=0, ERR=0, RX_DATA=0, S_DATA=0.
  - BCNT=0. PTR=N_REQ-1, so requester 0 has first priority.
  - The aborted transfer produces no DONE.

## Timing
- REQ is sampled in IDLE at edge k.
- LOAD runs during cycle k..k+1.
- SHIFT runs during cycles k+1 .. k+BITS+1.
- CAPTURE runs at edge k+BITS+1.
- DONE is high during cycle k+BITS+2..k+BITS+3.
- Transfer latency, REQ sample to DONE: BITS+2 cycles (10 for BITS=8).
- Minimum spacing between back-to-back grants: BITS+4 cycles, because there is one mandatory IDLE cycle.
- BUSY rises at edge k and falls at edge k+BITS+3.
- RX_DATA changes only at the CAPTURE edge or on reset.

## Test plan
- **Reset values:** hold CLR low, then release with all REQ=0. Required: GNT=0, DONE=0, BUSY=0, ERR=0, RX_DATA=8'h00. All strobes stay 0 for 20 cycles.
- **Single transfer:** REQ[1]=1, TX_DATA[1]=8'hA5, loopback SENDER OUT to RECEIVER IN. Required: one-cycle S_WRITE; exactly 8 cycles of S_TE; DONE[1] 10 cycles after the sample edge; RX_DATA=8'hA5; ERR=0.
- **Round-robin:** hold REQ=4'b1111 continuously. Required: grant order 0,1,2,3,0; each DONE spaced 12 cycles apart.
- **Request drop and late request:** drop REQ[2] mid-SHIFT. Required: DONE[2] still pulses. Raise REQ[0] mid-transfer. Required: GNT[0] only after the next IDLE.
- **Reset mid-operation:** assert CLR low at the 4th SHIFT cycle. Required: strobes and GNT go low immediately, no DONE, BUSY=0. After release, REQ[3] is granted normally.
- **Error detect:** force R_FULL=0 during CAPTURE. Required: ERR=1 after that edge. ERR stays 1 through later good transfers until CLR is asserted.
